// File: rtl/sgbm_minmax_pkg.sv
// rtl/sgbm_minmax_pkg.sv - shared min/min2/max/argmin record and merge function.
// Record widths are the package localparams; module Width/IdxWidth must match them.
package sgbm_minmax_pkg;

   localparam int MM_WIDTH     = 8;
   localparam int MM_IDX_WIDTH = 8;

   localparam logic [MM_WIDTH-1:0] MM_INF = '1;

   typedef struct packed {
      logic [MM_WIDTH-1:0]     min;
      logic [MM_WIDTH-1:0]     min2;
      logic [MM_WIDTH-1:0]     max;
      logic [MM_IDX_WIDTH-1:0] argmin;
   } minmax_rec_t;

   // a is always the lower-index side, so ties keep a's index and min2 may equal min
   function automatic minmax_rec_t merge_minmax(input minmax_rec_t a, input minmax_rec_t b);
      minmax_rec_t r;
      if (b.min < a.min) begin
         r.min    = b.min;
         r.argmin = b.argmin;
         r.min2   = (a.min < b.min2) ? a.min : b.min2;
      end else begin
         r.min    = a.min;
         r.argmin = a.argmin;
         r.min2   = (a.min2 < b.min) ? a.min2 : b.min;
      end
      r.max = (b.max > a.max) ? b.max : a.max;
      return r;
   endfunction

   // A lone element has no second value yet; the sentinel never beats a real one
   function automatic minmax_rec_t leaf_rec(input logic [MM_WIDTH-1:0] v,
                                            input logic [MM_IDX_WIDTH-1:0] idx);
      minmax_rec_t r;
      r.min    = v;
      r.min2   = MM_INF;
      r.max    = v;
      r.argmin = idx;
      return r;
   endfunction

   function automatic minmax_rec_t pad_rec();
      minmax_rec_t r;
      r.min    = MM_INF;
      r.min2   = MM_INF;
      r.max    = '0;
      r.argmin = '0;
      return r;
   endfunction

endpackage

// File: rtl/minmax_argmin_stream_if.sv
// rtl/minmax_argmin_stream_if.sv - beat input and result output handshake bundle.
interface minmax_argmin_stream_if #(
   parameter int Width    = 8,
   parameter int Lanes    = 4,
   parameter int IdxWidth = 8
);
   logic                   i_valid;
   logic                   i_ready;
   logic [Lanes*Width-1:0] i_data;
   logic                   i_last;
   logic                   o_valid;
   logic                   o_ready;
   logic [Width-1:0]       o_min;
   logic [Width-1:0]       o_min2;
   logic [Width-1:0]       o_max;
   logic [IdxWidth-1:0]    o_argmin;
   logic [IdxWidth:0]      o_count;

   modport master (
      output i_valid, i_data, i_last, o_ready,
      input  i_ready, o_valid, o_min, o_min2, o_max, o_argmin, o_count
   );

   modport slave (
      input  i_valid, i_data, i_last, o_ready,
      output i_ready, o_valid, o_min, o_min2, o_max, o_argmin, o_count
   );
endinterface

// File: rtl/minmax_argmin_stream_lane_reduce.sv
// rtl/minmax_argmin_stream_lane_reduce.sv - combinational log2(Lanes) merge tree over one beat.
module minmax_lane_reduce
   import sgbm_minmax_pkg::*;
#(
   parameter int Width    = MM_WIDTH,
   parameter int Lanes    = 4,
   parameter int IdxWidth = MM_IDX_WIDTH
) (
   input  logic [Lanes*Width-1:0] data,
   output logic [Width-1:0]       min,
   output logic [Width-1:0]       min2,
   output logic [Width-1:0]       max,
   output logic [IdxWidth-1:0]    lane
);

   localparam int Depth  = $clog2(Lanes);
   localparam int Leaves = 1 << Depth;

   minmax_rec_t t [Leaves];

   // In-place pairwise tree: t[i] always holds the lower-index half, so ties favour lower lanes
   always_comb begin
      for (int k = 0; k < Leaves; k++) begin
         if (k < Lanes) begin
            t[k] = leaf_rec(MM_WIDTH'(data[k*Width +: Width]), MM_IDX_WIDTH'(k));
         end else begin
            t[k] = pad_rec();
         end
      end
      for (int s = 1; s < Leaves; s = s * 2) begin
         for (int i = 0; i + s < Leaves; i = i + 2 * s) begin
            t[i] = merge_minmax(t[i], t[i+s]);
         end
      end
   end

   assign min  = t[0].min;
   assign min2 = t[0].min2;
   assign max  = t[0].max;
   assign lane = t[0].argmin;

endmodule

// File: rtl/minmax_argmin_stream.sv
// rtl/minmax_argmin_stream.sv - streaming group min/min2/max/argmin: lane reduce, accumulate, output.
module minmax_argmin_stream
   import sgbm_minmax_pkg::*;
#(
   parameter int Width    = MM_WIDTH,
   parameter int Lanes    = 4,
   parameter int IdxWidth = MM_IDX_WIDTH
) (
   input logic                    clk,
   input logic                    rst_n,
   minmax_argmin_stream_if.slave  bus
);

   localparam logic [IdxWidth+1:0] CNT_CAP = (IdxWidth+2)'(1) << IdxWidth;

   logic [1:0] rst_sync;
   logic       rst_int_n;

   // Reset asserts asynchronously everywhere but releases two edges later
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rst_sync <= '0;
      end else begin
         rst_sync <= {rst_sync[0], 1'b1};
      end
   end
   assign rst_int_n = rst_sync[1];

   logic en;
   logic accept;

   assign en          = !bus.o_valid || bus.o_ready;
   assign bus.i_ready = en;
   assign accept      = bus.i_valid && en;

   logic [Width-1:0]    r_min;
   logic [Width-1:0]    r_min2;
   logic [Width-1:0]    r_max;
   logic [IdxWidth-1:0] r_lane;

   minmax_lane_reduce #(
      .Width    (Width),
      .Lanes    (Lanes),
      .IdxWidth (IdxWidth)
   ) u_lane_reduce (
      .data (bus.i_data),
      .min  (r_min),
      .min2 (r_min2),
      .max  (r_max),
      .lane (r_lane)
   );

   logic [IdxWidth-1:0] base_idx;
   minmax_rec_t         beat_rec;

   always_comb begin
      beat_rec.min    = r_min;
      beat_rec.min2   = r_min2;
      beat_rec.max    = r_max;
      beat_rec.argmin = base_idx + r_lane;
   end

   logic        s1_valid;
   logic        s1_last;
   minmax_rec_t s1_rec;

   always_ff @(posedge clk or negedge rst_int_n) begin
      if (!rst_int_n) begin
         s1_valid <= 1'b0;
         s1_last  <= 1'b0;
         s1_rec   <= '0;
         base_idx <= '0;
      end else if (en) begin
         s1_valid <= accept;
         if (accept) begin
            s1_last  <= bus.i_last;
            s1_rec   <= beat_rec;
            base_idx <= bus.i_last ? '0 : base_idx + IdxWidth'(Lanes);
         end
      end
   end

   logic                acc_valid;
   minmax_rec_t         acc_rec;
   logic [IdxWidth:0]   acc_count;
   minmax_rec_t         merged;
   logic [IdxWidth+1:0] cnt_sum;
   logic [IdxWidth:0]   cnt_next;

   // An empty accumulator takes the beat as-is; overlong groups pin the count at 2^IdxWidth
   always_comb begin
      merged  = acc_valid ? merge_minmax(acc_rec, s1_rec) : s1_rec;
      cnt_sum = {1'b0, acc_count} + (IdxWidth+2)'(Lanes);
      if (!acc_valid) begin
         cnt_next = (IdxWidth+1)'(Lanes);
      end else if (cnt_sum > CNT_CAP) begin
         cnt_next = CNT_CAP[IdxWidth:0];
      end else begin
         cnt_next = cnt_sum[IdxWidth:0];
      end
   end

   always_ff @(posedge clk or negedge rst_int_n) begin
      if (!rst_int_n) begin
         acc_valid    <= 1'b0;
         acc_rec      <= '0;
         acc_count    <= '0;
         bus.o_valid  <= 1'b0;
         bus.o_min    <= '0;
         bus.o_min2   <= '0;
         bus.o_max    <= '0;
         bus.o_argmin <= '0;
         bus.o_count  <= '0;
      end else if (en) begin
         bus.o_valid <= s1_valid && s1_last;
         if (s1_valid) begin
            if (s1_last) begin
               bus.o_min    <= merged.min;
               bus.o_min2   <= merged.min2;
               bus.o_max    <= merged.max;
               bus.o_argmin <= merged.argmin;
               bus.o_count  <= cnt_next;
               acc_valid    <= 1'b0;
            end else begin
               acc_rec   <= merged;
               acc_count <= cnt_next;
               acc_valid <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_minmax_argmin_stream.sv
// tb/tb_minmax_argmin_stream.sv - scoreboard bench for minmax_argmin_stream.
module tb_minmax_argmin_stream;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   minmax_argmin_stream_if #(.Width(8), .Lanes(4), .IdxWidth(8)) bus();

   minmax_argmin_stream #(.Width(8), .Lanes(4), .IdxWidth(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct packed {
      logic [7:0] mn;
      logic [7:0] mn2;
      logic [7:0] mx;
      logic [7:0] arg;
      logic [8:0] cnt;
   } exp_t;

   typedef struct {
      int          n;
      logic [31:0] b0;
      logic [31:0] b1;
      logic [31:0] b2;
      exp_t        e;
   } vec_t;

   exp_t sb[$];
   int   hs_q[$];
   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   int   grp_elems = 0;
   int   acc_cyc = 0;

   always @(posedge clk) cyc++;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s got=%0d want=%0d", name, act, want);
      end
   endtask

   function automatic logic [31:0] pk(input int l0, input int l1, input int l2, input int l3);
      return {l3[7:0], l2[7:0], l1[7:0], l0[7:0]};
   endfunction

   function automatic exp_t mk(input int mn, input int mn2, input int mx, input int arg, input int cnt);
      exp_t e;
      e.mn = mn[7:0]; e.mn2 = mn2[7:0]; e.mx = mx[7:0]; e.arg = arg[7:0]; e.cnt = cnt[8:0];
      return e;
   endfunction

   // Reference: linear scan over element indices, independent of any tree structure
   function automatic exp_t model(input logic [31:0] beats[$]);
      exp_t        e;
      int          n;
      int          mn, mx, arg, mn2;
      logic [31:0] w;
      int          v;
      n = beats.size() * 4;
      mn = 0; mx = 0; arg = 0; mn2 = 256;
      for (int i = 0; i < n; i++) begin
         w = beats[i/4];
         v = int'(w[(i%4)*8 +: 8]);
         if (i == 0 || v < mn) begin mn = v; arg = i; end
         if (i == 0 || v > mx) mx = v;
      end
      for (int i = 0; i < n; i++) begin
         w = beats[i/4];
         v = int'(w[(i%4)*8 +: 8]);
         if (i != arg && v < mn2) mn2 = v;
      end
      return mk(mn, mn2, mx, arg, (n > 256) ? 256 : n);
   endfunction

   always @(negedge clk) begin
      exp_t e;
      if (rst_n && bus.o_valid && bus.o_ready) begin
         hs_q.push_back(cyc);
         if (sb.size() == 0) begin
            chk("unexpected_result", 32'd1, 32'd0);
         end else begin
            e = sb.pop_front();
            chk("o_min",    32'(bus.o_min),    32'(e.mn));
            chk("o_min2",   32'(bus.o_min2),   32'(e.mn2));
            chk("o_max",    32'(bus.o_max),    32'(e.mx));
            chk("o_argmin", 32'(bus.o_argmin), 32'(e.arg));
            chk("o_count",  32'(bus.o_count),  32'(e.cnt));
         end
      end
   end

   task automatic send_beat(input logic [31:0] d, input logic last);
      int  waited;
      bit  done;
      waited = 0;
      done = 0;
      bus.i_valid = 1'b1;
      bus.i_data  = d;
      bus.i_last  = last;
      while (!done) begin
         @(negedge clk);
         if (bus.i_ready) begin
            done = 1;
            acc_cyc = cyc;
         end else begin
            waited++;
            if (waited > 200) begin
               chk("i_ready_timeout", 32'd0, 32'd1);
               done = 1;
            end
         end
      end
      @(posedge clk);
      #1;
      bus.i_valid = 1'b0;
      bus.i_last  = 1'b0;
      grp_elems += 4;
      if (last) begin
         chk("group_len_le_256", 32'(grp_elems <= 256), 32'd1);
         grp_elems = 0;
      end
   endtask

   task automatic send_group(input logic [31:0] beats[$], input exp_t e);
      sb.push_back(e);
      for (int i = 0; i < beats.size(); i++) send_beat(beats[i], i == beats.size() - 1);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb.size() > 0 && n < 300) begin
         @(posedge clk);
         n++;
      end
      chk("scoreboard_drained", 32'(sb.size()), 32'd0);
      sb.delete();
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic check_reset_state(input string tag);
      @(negedge clk);
      chk({tag, "_o_valid"},  32'(bus.o_valid),  32'd0);
      chk({tag, "_o_min"},    32'(bus.o_min),    32'd0);
      chk({tag, "_o_min2"},   32'(bus.o_min2),   32'd0);
      chk({tag, "_o_max"},    32'(bus.o_max),    32'd0);
      chk({tag, "_o_argmin"}, 32'(bus.o_argmin), 32'd0);
      chk({tag, "_o_count"},  32'(bus.o_count),  32'd0);
      chk({tag, "_i_ready"},  32'(bus.i_ready),  32'd1);
      @(posedge clk);
      #1;
   endtask

   initial begin
      repeat (30000) @(posedge clk);
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog");
   end

   vec_t        tbl[6];
   logic [31:0] bq[$];
   int          first_acc;

   initial begin
      tbl[0] = '{1, pk(7,3,9,3), 0, 0, mk(3, 3, 9, 1, 4)};
      tbl[1] = '{3, pk(10,20,30,40), pk(5,50,60,70), pk(8,6,90,5), mk(5, 5, 90, 4, 12)};
      tbl[2] = '{1, pk(4,1,2,0), 0, 0, mk(0, 1, 4, 3, 4)};
      tbl[3] = '{2, pk(0,0,0,0), pk(255,255,255,255), 0, mk(0, 0, 255, 0, 8)};
      tbl[4] = '{2, pk(100,90,80,70), pk(60,50,40,30), 0, mk(30, 40, 100, 7, 8)};
      tbl[5] = '{3, pk(9,9,9,9), pk(9,9,9,2), pk(3,200,7,8), mk(2, 3, 200, 7, 12)};

      bus.i_valid = 1'b0;
      bus.i_data  = '0;
      bus.i_last  = 1'b0;
      bus.o_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      check_reset_state("reset");

      for (int v = 0; v < 6; v++) begin
         bq.delete();
         bq.push_back(tbl[v].b0);
         if (tbl[v].n > 1) bq.push_back(tbl[v].b1);
         if (tbl[v].n > 2) bq.push_back(tbl[v].b2);
         send_group(bq, tbl[v].e);
      end
      drain();

      // Output stall: result held, i_ready low, next group's beats not lost
      bus.o_ready = 1'b0;
      sb.push_back(mk(40, 45, 60, 1, 4));
      send_beat(pk(50,40,60,45), 1'b1);
      fork
         begin
            bq.delete();
            bq.push_back(pk(11,12,13,14));
            bq.push_back(pk(15,16,17,10));
            send_group(bq, mk(10, 11, 17, 7, 8));
         end
         begin
            int w;
            w = 0;
            @(negedge clk);
            while (!bus.o_valid && w < 10) begin
               @(negedge clk);
               w++;
            end
            for (int k = 0; k < 5; k++) begin
               chk("stall_o_valid",  32'(bus.o_valid),  32'd1);
               chk("stall_i_ready",  32'(bus.i_ready),  32'd0);
               chk("stall_o_min",    32'(bus.o_min),    32'd40);
               chk("stall_o_argmin", 32'(bus.o_argmin), 32'd1);
               chk("stall_o_max",    32'(bus.o_max),    32'd60);
               @(negedge clk);
            end
            @(posedge clk);
            #1 bus.o_ready = 1'b1;
         end
      join
      drain();

      // Reset mid-group: two beats of zeros must leave no trace
      send_beat(pk(0,0,0,0), 1'b0);
      send_beat(pk(0,0,0,0), 1'b0);
      grp_elems = 0;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      check_reset_state("midreset");
      bq.delete();
      bq.push_back(pk(1,2,3,4));
      send_group(bq, mk(1, 2, 4, 0, 4));
      drain();

      // Longest legal group: 256 equal elements
      bq.delete();
      for (int i = 0; i < 64; i++) bq.push_back(pk(255,255,255,255));
      send_group(bq, mk(255, 255, 255, 0, 256));
      drain();

      // Back-to-back single-beat groups: latency 2, one result per cycle
      hs_q.delete();
      first_acc = -1;
      for (int g = 0; g < 4; g++) begin
         bq.delete();
         bq.push_back({8'($urandom_range(0,15)), 8'($urandom_range(0,15)),
                       8'($urandom_range(0,15)), 8'($urandom_range(0,15))});
         send_group(bq, model(bq));
         if (g == 0) first_acc = acc_cyc;
      end
      drain();
      chk("b2b_result_count", 32'(hs_q.size()), 32'd4);
      if (hs_q.size() >= 4) begin
         chk("b2b_latency", 32'(hs_q[0]), 32'(first_acc + 2));
         for (int i = 1; i < 4; i++) chk("b2b_no_bubble", 32'(hs_q[i]), 32'(hs_q[0] + i));
      end

      // Random back-to-back groups of 1..3 beats with many ties
      for (int g = 0; g < 10; g++) begin
         int nb;
         nb = $urandom_range(1, 3);
         bq.delete();
         for (int b = 0; b < nb; b++) begin
            bq.push_back({8'($urandom_range(0,15)), 8'($urandom_range(0,15)),
                          8'($urandom_range(0,15)), 8'($urandom_range(0,15))});
         end
         send_group(bq, model(bq));
      end
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/minmax_argmin_stream.md
Name: minmax_argmin_stream

Overview:
- Streaming successor to the 3-input min/max comparator.
- Accepts a group of cost values, Lanes values per beat, over any number of beats ended by i_last.
- Outputs per group: min, max, index of min (argmin) and second-smallest value.
- Sits between the SGBM aggregated-cost path and disparity selection / uniqueness check, one group per pixel.

Parameters:
- Width, 8: bits per cost value (unsigned).
- Lanes, 4: values per input beat; legal values are 2 to 16.
- IdxWidth, 8: width of element index; a group holds at most 2^IdxWidth elements.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- i_valid  input  1  input beat valid.
- i_ready  output  1  block can accept a beat this cycle.
- i_data  input  Lanes*Width  lane k is bits [k*Width +: Width]; element index = beat*Lanes + k.
- i_last  input  1  final beat of the group.
- o_valid  output  1  result valid; held until accepted.
- o_ready  input  1  downstream accepts the result.
- o_min  output  Width  smallest value in the group.
- o_min2  output  Width  smallest value at any index other than o_argmin.
- o_max  output  Width  largest value in the group.
- o_argmin  output  IdxWidth  lowest index holding o_min.
- o_count  output  IdxWidth+1  number of elements in the group.

Behaviour:
- Reset (async assert, synchronous deassert inside the block):
  - o_valid=0; o_min, o_min2, o_max, o_argmin, o_count = 0.
  - Beat counter = 0, stage-1 valid = 0, accumulator empty.
  - A partial group in flight is discarded.
- Global enable: en = !o_valid || o_ready. i_ready = en (combinational from o_valid and o_ready). A beat is accepted when i_valid && i_ready.
- When en=0, every register holds: stage 1, accumulator, beat counter and outputs.
- Stage 1 (registered, accept cycle t -> valid at t+1):
  - Lane reduction produces beat min, min2, max, lane argmin, the beat's base index and last flag.
  - Strict less-than comparisons, so lower lanes win ties.
  - Beat counter increments per accepted beat and clears on accepted i_last.
- Stage 2 (accumulator, t+1 -> t+2):
  - First beat of a group (accumulator empty) loads directly.
  - Otherwise merge accumulator A with beat B:
    - If B.min < A.min: min=B.min, argmin=B.arg, min2=min(A.min, B.min2).
    - Else: min=A.min, argmin=A.arg, min2=min(A.min2, B.min).
    - max=max(A.max, B.max).
  - Ties keep the earlier index, so argmin is the lowest index and min2 may equal min.
  - o_count += Lanes.
- Output: when stage 1 holds a last beat and en=1, the merged result is written to the outputs and o_valid=1 on the next edge. The accumulator returns to empty in the same cycle.
- Latency: i_last accepted at cycle t -> o_valid=1 at t+2 (no stall).
- Throughput: 1 beat/cycle. Back-to-back groups need no bubble.
- o_valid clears after o_valid && o_ready unless a new result is written in the same cycle; that new result replaces the old one.
- Outputs are stable while o_valid && !o_ready.
- Single-beat group (i_last on first beat): result formed from the lane reduction alone, o_count=Lanes.
- Index overflow: a group longer than 2^IdxWidth elements is illegal. The beat counter wraps modulo 2^IdxWidth/Lanes, o_count saturates at 2^IdxWidth, and o_argmin is not guaranteed. The bench asserts it never occurs.
- Values are unsigned; no arithmetic beyond compares. All widths are exact, with no sign extension.

Decomposition:
- Shared package sgbm_minmax_pkg holds:
  - typedef minmax_rec_t {min, min2, max, argmin} parameterised via macros/localparams.
  - Function merge_minmax(A, B) used by the accumulator and by the lane tree.
- Sub-module minmax_lane_reduce (combinational):
  - Lanes inputs -> min, min2, max and lane index.
  - Built as a log2(Lanes) tree of merge_minmax; it is the N-input generalisation of the 3-input block.

Test Plan (Width=8, Lanes=4, IdxWidth=8):
- Single beat {lane0..3}={7,3,9,3}, i_last=1, o_ready=1 -> 2 cycles later o_min=3, o_argmin=1, o_min2=3, o_max=9, o_count=4.
- Three beats {10,20,30,40},{5,50,60,70},{8,6,90,5}, last on beat 3 -> o_min=5, o_argmin=4, o_min2=5, o_max=90, o_count=12.
- Back-to-back groups with i_valid held high, o_ready=1 -> results on consecutive o_valid cycles, no bubble, no cross-group mixing.
- o_ready=0 for 5 cycles while o_valid=1 -> i_ready=0, outputs constant, no beat lost; release -> next result correct.
- Assert rst_n low mid-group after 2 beats, then send fresh group {1,2,3,4} last -> o_min=1, o_argmin=0, o_count=4, with no trace of the aborted group.
- All-equal group of 64 beats of 255 -> o_min=o_min2=o_max=255, o_argmin=0, o_count=256.
